// File: rtl/torque_pkg.sv
// torque_pkg: shared direction, torque and sequencer state types
package torque_pkg;
    typedef enum logic [1:0] {STOP = 2'b00, LEFT = 2'b01, RIGHT = 2'b10, REVERSE = 2'b11} instr_t;
    typedef logic [1:0] torque_t;
    localparam torque_t TORQUE_MAX = 2'd3;
    typedef enum logic [1:0] {HOLD, RAMP_DOWN, SWITCH, RAMP} seq_state_t;
endpackage

// File: rtl/step_timer.sv
// step_timer: free-running step interval counter, restarted by clear
module step_timer #(
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
    logic [W-1:0] cnt;
    always_comb tick = cnt == W'(STEP_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/torque_command_sequencer.sv
// torque_command_sequencer: ramps torque toward commanded target, through zero on direction change
module torque_command_sequencer import torque_pkg::*; #(
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_instruction,
    input  logic [1:0] cmd_torque,
    output logic       cmd_ready,
    output logic       enable,
    output logic [1:0] instruction,
    output logic [1:0] torque,
    output logic       busy
);
    seq_state_t state, state_next;
    instr_t     tgt_instr, req_instr;
    torque_t    tgt_torque, req_torque, torque_step;
    logic       tick, accept, clear;
    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= HOLD;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            HOLD:      state_next = !accept ? HOLD :
                                    req_instr != instruction ? (torque != '0 ? RAMP_DOWN : SWITCH) :
                                    req_torque != torque ? RAMP : HOLD;
            RAMP_DOWN: state_next = tick && torque == 2'd1 ? SWITCH : RAMP_DOWN;
            SWITCH:    state_next = tgt_torque != '0 ? RAMP : HOLD;
            RAMP:      state_next = tick && torque_step == tgt_torque ? HOLD : RAMP;
            default:   state_next = HOLD;
        endcase
    end
    always_comb begin
        cmd_ready   = state == HOLD;
        busy        = !cmd_ready;
        accept      = cmd_valid && cmd_ready;
        clear       = state_next != state;
        req_instr   = instr_t'(cmd_instruction);
        req_torque  = req_instr == STOP ? '0 : cmd_torque;
        torque_step = tgt_torque > torque ? torque + 2'd1 : torque - 2'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= STOP;
            torque      <= '0;
            enable      <= 1'b0;
            tgt_instr   <= STOP;
            tgt_torque  <= '0;
        end else begin
            if (accept) begin
                tgt_instr  <= req_instr;
                tgt_torque <= req_torque;
            end
            if (tick && state == RAMP_DOWN) torque <= torque - 2'd1;
            if (tick && state == RAMP) torque <= torque_step;
            if (state == SWITCH) begin
                instruction <= tgt_instr;
                enable      <= tgt_instr != STOP;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && tick)
            assert (!(state == RAMP_DOWN && torque == '0) &&
                    !(state == RAMP && (tgt_torque > torque ? torque == TORQUE_MAX : torque == '0)));
    end
endmodule

// File: tb/tb_torque_command_sequencer.sv
// tb_torque_command_sequencer: directed table-driven checks of the torque sequencer with STEP_CYCLES=4
module tb_torque_command_sequencer;
    import torque_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_instruction = 2'b00;
    logic [1:0] cmd_torque = 2'b00;
    logic       cmd_ready, enable, busy;
    logic [1:0] instruction, torque;
    int checks = 0;
    int fails = 0;
    typedef struct {
        logic       v;
        logic [1:0] ci;
        logic [1:0] ct;
        logic [1:0] ei;
        logic [1:0] et;
        logic       ee;
        logic       er;
    } vec_t;
    vec_t spin[14];
    torque_command_sequencer #(.STEP_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_instruction(cmd_instruction),
        .cmd_torque     (cmd_torque),
        .cmd_ready      (cmd_ready),
        .enable         (enable),
        .instruction    (instruction),
        .torque         (torque),
        .busy           (busy)
    );
    always #5 clk = ~clk;
    task automatic cmp(input string tag, input string sig, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s %s at %0t: got %0d expected %0d", tag, sig, $time, act, exp);
        end
    endtask
    task automatic cyc(input string tag, input logic r, input logic v, input logic [1:0] ci, input logic [1:0] ct,
                       input logic [1:0] ei, input logic [1:0] et, input logic ee, input logic er);
        rst = r;
        cmd_valid = v;
        cmd_instruction = ci;
        cmd_torque = ct;
        @(posedge clk);
        #1;
        cmp(tag, "instruction", instruction, ei);
        cmp(tag, "torque", torque, et);
        cmp(tag, "enable", {1'b0, enable}, {1'b0, ee});
        cmp(tag, "cmd_ready", {1'b0, cmd_ready}, {1'b0, er});
        cmp(tag, "busy", {1'b0, busy}, {1'b0, !er});
    endtask
    task automatic run_spin(input string tag, input int n, input bit noisy);
        for (int i = 0; i < n; i++)
            cyc(tag, 1'b0, spin[i].v || (noisy && i > 0), (noisy && i > 0) ? RIGHT : spin[i].ci, spin[i].ct,
                spin[i].ei, spin[i].et, spin[i].ee, spin[i].er);
    endtask
    initial begin
        for (int e = 0; e < 14; e++)
            spin[e] = '{v: e == 0, ci: LEFT, ct: 2'd3, ei: e >= 1 ? LEFT : STOP,
                        et: e >= 13 ? 2'd3 : e >= 9 ? 2'd2 : e >= 5 ? 2'd1 : 2'd0, ee: e >= 1, er: e >= 13};
        cyc("reset", 1'b1, 1'b0, STOP, 2'd0, STOP, 2'd0, 1'b0, 1'b1);
        cyc("reset", 1'b1, 1'b0, STOP, 2'd0, STOP, 2'd0, 1'b0, 1'b1);
        cyc("idle", 1'b0, 1'b0, STOP, 2'd0, STOP, 2'd0, 1'b0, 1'b1);
        run_spin("spinup", 14, 1'b0);
        cyc("repeat", 1'b0, 1'b1, LEFT, 2'd3, LEFT, 2'd3, 1'b1, 1'b1);
        for (int e = 0; e < 3; e++) cyc("repeat_idle", 1'b0, 1'b0, LEFT, 2'd3, LEFT, 2'd3, 1'b1, 1'b1);
        for (int e = 0; e <= 8; e++)
            cyc("reduce", 1'b0, e == 0, LEFT, 2'd1, LEFT, e < 4 ? 2'd3 : e < 8 ? 2'd2 : 2'd1, 1'b1, e >= 8);
        for (int e = 0; e <= 8; e++)
            cyc("stop", 1'b0, e == 0, STOP, 2'd3, e < 5 ? LEFT : STOP, e < 4 ? 2'd1 : 2'd0, e < 5, e >= 5);
        run_spin("busy", 14, 1'b1);
        cyc("busy_done", 1'b0, 1'b0, STOP, 2'd0, LEFT, 2'd3, 1'b1, 1'b1);
        for (int e = 0; e <= 22; e++)
            cyc("reversal", 1'b0, e == 0, RIGHT, 2'd2, e < 13 ? LEFT : RIGHT,
                e < 4 ? 2'd3 : e < 8 ? 2'd2 : e < 12 ? 2'd1 : e < 17 ? 2'd0 : e < 21 ? 2'd1 : 2'd2, 1'b1, e >= 21);
        cyc("reset2", 1'b1, 1'b0, STOP, 2'd0, STOP, 2'd0, 1'b0, 1'b1);
        run_spin("partial", 7, 1'b0);
        cyc("mid_reset", 1'b1, 1'b0, STOP, 2'd0, STOP, 2'd0, 1'b0, 1'b1);
        run_spin("respin", 14, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/torque_command_sequencer.md
# torque_command_sequencer

Produces the `instruction`/`torque`/`enable` triple consumed by `torque_display` and the motor drive path. It accepts direction/torque commands over a valid/ready handshake and ramps torque one level per step interval toward the target. Torque always ramps to zero before the direction changes, so downstream logic never sees a non-zero torque applied to a new direction.

## Interface
Parameters:
- `STEP_CYCLES`, default 50_000_000: clock cycles per torque step (1 s at 50 MHz). Legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; everything is clocked on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_instruction`  in  2  requested direction (`instr_t`).
- `cmd_torque`  in  2  requested torque level, 0–3.
- `cmd_ready`  out  1  sequencer can accept a command.
- `enable`  out  1  drive/display enable.
- `instruction`  out  2  current direction (`instr_t`).
- `torque`  out  2  current torque level.
- `busy`  out  1  a ramp is in progress (`!cmd_ready`).

## Operation
- Direction encoding (`instr_t`): 00 STOP, 01 LEFT, 10 RIGHT, 11 REVERSE.
- STOP forces the target torque to 0. `cmd_torque` is ignored with STOP.
- All outputs are registered. `cmd_ready = (state == HOLD)`, `busy = !cmd_ready`.
- Reset values: state HOLD, `instruction` STOP, `torque` 0, `enable` 0, step timer 0. This gives `cmd_ready` 1 and `busy` 0.
- Internal targets `tgt_instr` and `tgt_torque` are latched on accept (`cmd_valid && cmd_ready`).
- The step timer clears on every state entry. It produces `tick` on the cycle where count == STEP_CYCLES-1, then wraps to 0.

State machine:
- **HOLD**: on accept:
  - target equals current: stay in HOLD.
  - instruction differs and `torque != 0`: go to RAMP_DOWN.
  - instruction differs and `torque == 0`: go to SWITCH.
  - same instruction, different torque: go to RAMP.
- **RAMP_DOWN**: on tick, `torque <= torque-1`. When the new value is 0, go to SWITCH on the same edge.
- **SWITCH**: one cycle only.
  - `instruction <= tgt_instr`, `enable <= (tgt_instr != STOP)`.
  - Next state is RAMP if `tgt_torque != 0`, else HOLD.
- **RAMP**: on tick, `torque` moves ±1 toward `tgt_torque`. When the new value equals the target, go to HOLD on the same edge.
- Torque arithmetic is unsigned 2-bit. It is never incremented past 3 or decremented below 0; saturation is guaranteed by the state rules and checked by an assertion.
- `cmd_valid` while not ready is ignored: no latch, no queue. Commands are not preempted.
- `rst` mid-operation returns every output and the state to its reset value on the next edge. A partial ramp is discarded.

## Timing
- Accept edge is N.
- SWITCH path: `instruction`/`enable` update at N+1. The first torque step is at N+1+STEP_CYCLES, and each later step is STEP_CYCLES after the previous one.
- RAMP or RAMP_DOWN from HOLD: the first step is at N+STEP_CYCLES.
- Full reversal from torque T to a new direction at torque U:
  - `instruction` changes at N+T·S+1, where S = STEP_CYCLES.
  - HOLD is reached at N+T·S+1+U·S.
- `cmd_ready` rises the cycle after the edge that enters HOLD. The earliest next accept is that cycle.
- With STEP_CYCLES=1, torque changes on every edge while ramping.

## Structure
- Shared package `torque_pkg` holds:
  - `instr_t` enum (STOP/LEFT/RIGHT/REVERSE), also used by `torque_display`.
  - `torque_t` (`logic [1:0]`) and `TORQUE_MAX` = 3.
  - the state enum `seq_state_t` (HOLD, RAMP_DOWN, SWITCH, RAMP).
- Sub-module `step_timer`:
  - parameter STEP_CYCLES; ports `clk`, `rst`, `clear`, `tick`.
  - counter width `$clog2(STEP_CYCLES)`, minimum 1 bit.

## Test plan
All scenarios use STEP_CYCLES=4.
- **Reset**: hold `rst` for 2 cycles → `instruction`=00, `torque`=0, `enable`=0, `cmd_ready`=1, `busy`=0.
- **Spin-up**: from reset, accept LEFT/3 at edge 0 → `instruction`=01 and `enable`=1 at edge 1; `torque` 1/2/3 at edges 5/9/13; `cmd_ready`=1 from cycle 14.
- **Reversal**: from LEFT/3, accept RIGHT/2 at edge 0 → `torque` 2/1/0 at edges 4/8/12; `instruction`=10 at 13; `torque` 1/2 at 17/21; `instruction` never changes while `torque`≠0.
- **Same-direction reduction and STOP**:
  - from LEFT/3, accept LEFT/1 → `torque` 2 at edge 4, 1 at edge 8, `instruction` stays 01.
  - then accept STOP/3 → ramps to 0, `instruction`=00, `enable`=0, `torque` stays 0.
- **Busy and repeat**:
  - assert `cmd_valid` with RIGHT/3 throughout a ramp → ignored; the original target completes.
  - accept a command identical to the current state → no output change, `cmd_ready` stays 1.
- **Reset mid-ramp**: assert `rst` at edge 6 of spin-up → `torque`=0, `instruction`=00, `enable`=0 at edge 7; a new accept after release behaves as in Spin-up.
